// File: rtl/pwm_capture_xy.sv
// pwm_capture_xy: dual-channel servo-pulse decoder.
// Measures the high time W of Pulse_X / Pulse_Y and recovers the duty code that produced it,
// where W = BASE_TICKS + duty * STEP_TICKS sysclk cycles.
//
// Ports:
//   sysclk          system clock
//   reset           synchronous, active-high reset
//   Pulse_X/Y       asynchronous servo pulse inputs
//   Duty_X/Y[5:0]   last committed duty code per channel
//   Valid_X/Y       one-cycle strobe, Duty updated this cycle
//   Err_X/Y         last decoded pulse was out of range
//   Lost_X/Y        no rising edge seen within TIMEOUT_TICKS
//
// Build option: define PWM_CAP_CONFIRM_EN to commit a decode only when it matches the previous
// decode of the same channel.
module pwm_capture_xy #(
    parameter int unsigned BASE_TICKS    = 100000,
    parameter int unsigned STEP_TICKS    = 1563,
    parameter int unsigned TIMEOUT_TICKS = 3000000
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       Pulse_X,
    input  logic       Pulse_Y,
    output logic [5:0] Duty_X,
    output logic [5:0] Duty_Y,
    output logic       Valid_X,
    output logic       Valid_Y,
    output logic       Err_X,
    output logic       Err_Y,
    output logic       Lost_X,
    output logic       Lost_Y
);

    localparam int unsigned BW = $clog2(BASE_TICKS + 1);
    localparam int unsigned SW = $clog2(STEP_TICKS + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [1:0] {StArm, StIdle, StBase, StStep} state_e;

    logic [1:0] pin;
    logic [5:0] duty_arr  [2];
    logic       valid_arr [2];
    logic       err_arr   [2];
    logic       lost_arr  [2];

    assign pin = {Pulse_Y, Pulse_X};

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic          sync1_q, sync2_q, lvl_q, rise_q, fall_q;
        state_e        state_q, state_d;
        logic [BW-1:0] base_cnt_q, base_cnt_d;
        logic [SW-1:0] sub_cnt_q, sub_cnt_d;
        logic [6:0]    step_cnt_q, step_cnt_d;
        logic          dec, dec_err, commit, lost_hit;
        logic [5:0]    dec_duty;
        logic [TW-1:0] per_cnt_q;
        logic [5:0]    duty_q;
        logic          valid_q, err_q, lost_q;

        // Synchronizer and level pipeline are left unreset so that a pulse already high when
        // reset releases is seen as high (ARM then waits it out) rather than as a fresh edge.
        always_ff @(posedge sysclk) begin
            sync1_q <= pin[c];
            sync2_q <= sync1_q;
            lvl_q   <= sync2_q;
        end

        // rise_q / fall_q are aligned with lvl_q: rise_q marks the first high cycle of lvl_q,
        // fall_q the first low one.
        always_ff @(posedge sysclk) begin
            if (reset) begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= sync2_q & ~lvl_q;
                fall_q <= ~sync2_q & lvl_q;
            end
        end

        always_ff @(posedge sysclk) begin
            if (reset) begin
                state_q    <= StArm;
                base_cnt_q <= '0;
                sub_cnt_q  <= '0;
                step_cnt_q <= '0;
            end else begin
                state_q    <= state_d;
                base_cnt_q <= base_cnt_d;
                sub_cnt_q  <= sub_cnt_d;
                step_cnt_q <= step_cnt_d;
            end
        end

        always_comb begin
            state_d    = state_q;
            base_cnt_d = base_cnt_q;
            sub_cnt_d  = sub_cnt_q;
            step_cnt_d = step_cnt_q;
            dec        = 1'b0;
            dec_duty   = '0;
            dec_err    = 1'b0;
            unique case (state_q)
                StArm: begin
                    if (!lvl_q) state_d = StIdle;
                end
                StIdle: begin
                    if (rise_q) begin
                        // The rising-edge cycle is the first counted high cycle.
                        base_cnt_d = BW'(1);
                        sub_cnt_d  = '0;
                        step_cnt_d = '0;
                        state_d    = (BASE_TICKS <= 1) ? StStep : StBase;
                    end
                end
                StBase: begin
                    if (fall_q) begin
                        dec     = 1'b1;
                        dec_err = 1'b1;
                        state_d = StIdle;
                    end else if (base_cnt_q == BW'(BASE_TICKS - 1)) begin
                        state_d = StStep;
                    end else begin
                        base_cnt_d = base_cnt_q + BW'(1);
                    end
                end
                StStep: begin
                    if (fall_q) begin
                        dec      = 1'b1;
                        dec_duty = step_cnt_q[6] ? 6'd63 : step_cnt_q[5:0];
                        dec_err  = step_cnt_q[6];
                        state_d  = StIdle;
                    end else if (sub_cnt_q == SW'(STEP_TICKS - 1)) begin
                        sub_cnt_d = '0;
                        if (step_cnt_q != 7'd64) step_cnt_d = step_cnt_q + 7'd1;
                    end else begin
                        sub_cnt_d = sub_cnt_q + SW'(1);
                    end
                end
                default: state_d = StArm;
            endcase
        end

        // Lost fires once, on the cycle the period counter reaches the limit, so a decode that
        // completes while the counter sits saturated can still clear it.
        assign lost_hit = !rise_q && (per_cnt_q == TW'(TIMEOUT_TICKS - 1));

        always_ff @(posedge sysclk) begin
            if (reset) begin
                per_cnt_q <= '0;
            end else if (rise_q) begin
                per_cnt_q <= '0;
            end else if (per_cnt_q != TW'(TIMEOUT_TICKS)) begin
                per_cnt_q <= per_cnt_q + TW'(1);
            end
        end

`ifdef PWM_CAP_CONFIRM_EN
        logic [5:0] shadow_q;
        logic       shadow_vld_q;

        assign commit = dec && shadow_vld_q && (shadow_q == dec_duty);

        always_ff @(posedge sysclk) begin
            if (reset) begin
                shadow_q     <= '0;
                shadow_vld_q <= 1'b0;
            end else begin
                if (dec) begin
                    shadow_q     <= dec_duty;
                    shadow_vld_q <= ~dec_err;
                end
                if (lost_hit) shadow_vld_q <= 1'b0;
            end
        end
`else
        assign commit = dec;
`endif

        always_ff @(posedge sysclk) begin
            if (reset) begin
                duty_q  <= '0;
                valid_q <= 1'b0;
                err_q   <= 1'b0;
                lost_q  <= 1'b0;
            end else begin
                valid_q <= commit;
                if (commit) duty_q <= dec_duty;
                if (dec) err_q <= dec_err;
                if (lost_hit) begin
                    lost_q <= 1'b1;
                end else if (commit) begin
                    lost_q <= 1'b0;
                end
            end
        end

        assign duty_arr[c]  = duty_q;
        assign valid_arr[c] = valid_q;
        assign err_arr[c]   = err_q;
        assign lost_arr[c]  = lost_q;
    end

    assign Duty_X  = duty_arr[0];
    assign Duty_Y  = duty_arr[1];
    assign Valid_X = valid_arr[0];
    assign Valid_Y = valid_arr[1];
    assign Err_X   = err_arr[0];
    assign Err_Y   = err_arr[1];
    assign Lost_X  = lost_arr[0];
    assign Lost_Y  = lost_arr[1];

endmodule

// File: tb/tb_pwm_capture_xy.sv
// tb_pwm_capture_xy: directed self-checking bench for pwm_capture_xy with small tick counts
// (BASE_TICKS = 20, STEP_TICKS = 4, TIMEOUT_TICKS = 400).
// Honours PWM_CAP_CONFIRM_EN to exercise the decode-confirm build.
module tb_pwm_capture_xy;

    localparam int unsigned Base    = 20;
    localparam int unsigned Step    = 4;
    localparam int unsigned Timeout = 400;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic       Pulse_X = 1'b0;
    logic       Pulse_Y = 1'b0;
    logic [5:0] Duty_X, Duty_Y;
    logic       Valid_X, Valid_Y, Err_X, Err_Y, Lost_X, Lost_Y;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int vx_cnt   = 0;
    int vy_cnt   = 0;
    int vx_cyc   = 0;
    int vy_cyc   = 0;
    int fall_cyc = 0;
    int bx, by;

    pwm_capture_xy #(
        .BASE_TICKS    (Base),
        .STEP_TICKS    (Step),
        .TIMEOUT_TICKS (Timeout)
    ) u_dut (
        .sysclk  (sysclk),
        .reset   (reset),
        .Pulse_X (Pulse_X),
        .Pulse_Y (Pulse_Y),
        .Duty_X  (Duty_X),
        .Duty_Y  (Duty_Y),
        .Valid_X (Valid_X),
        .Valid_Y (Valid_Y),
        .Err_X   (Err_X),
        .Err_Y   (Err_Y),
        .Lost_X  (Lost_X),
        .Lost_Y  (Lost_Y)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    // Record every Valid strobe and the cycle it was seen in.
    always @(negedge sysclk) begin
        if (Valid_X) begin
            vx_cnt <= vx_cnt + 1;
            vx_cyc <= cyc;
        end
        if (Valid_Y) begin
            vy_cnt <= vy_cnt + 1;
            vy_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clock edges; inputs change 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    // Drive a w-cycle high pulse on one channel, then hold low for gap cycles.
    task automatic pulse(input bit ch_y, input int w, input int gap);
        if (ch_y) Pulse_Y = 1'b1;
        else      Pulse_X = 1'b1;
        step(w);
        if (ch_y) Pulse_Y = 1'b0;
        else      Pulse_X = 1'b0;
        fall_cyc = cyc;
        step(gap);
    endtask

    // X high 60 and Y high 80, both falling on the same cycle.
    task automatic pulse_xy();
        Pulse_Y = 1'b1;
        step(20);
        Pulse_X = 1'b1;
        step(60);
        Pulse_X = 1'b0;
        Pulse_Y = 1'b0;
        fall_cyc = cyc;
        step(30);
    endtask

    initial begin
        step(4);
        check("outs_in_reset", int'({Duty_X, Duty_Y, Valid_X, Valid_Y, Err_X, Err_Y,
                                     Lost_X, Lost_Y}), 0);
        reset = 1'b0;
        step(1);
        check("outs_after_reset", int'({Duty_X, Duty_Y, Valid_X, Valid_Y, Err_X, Err_Y,
                                        Lost_X, Lost_Y}), 0);
        step(5);

`ifdef PWM_CAP_CONFIRM_EN
        bx = vx_cnt;
        pulse(1'b0, 60, 30);
        pulse(1'b0, 64, 30);
        check("cfm_no_commit_yet", vx_cnt - bx, 0);
        check("cfm_duty_held", int'(Duty_X), 0);
        pulse(1'b0, 64, 30);
        check("cfm_one_valid", vx_cnt - bx, 1);
        check("cfm_duty", int'(Duty_X), 11);
        check("cfm_latency", vx_cyc - fall_cyc, 4);
        check("cfm_err", int'(Err_X), 0);

        bx = vx_cnt;
        by = vy_cnt;
        pulse_xy();
        pulse_xy();
        check("cfm_xy_vx", vx_cnt - bx, 1);
        check("cfm_xy_vy", vy_cnt - by, 1);
        check("cfm_xy_same_cyc", vx_cyc - vy_cyc, 0);
        check("cfm_xy_duty_x", int'(Duty_X), 10);
        check("cfm_xy_duty_y", int'(Duty_Y), 15);
`else
        // In-range decode and output latency.
        bx = vx_cnt;
        pulse(1'b0, 60, 100);
        check("x60_valid_cnt", vx_cnt - bx, 1);
        check("x60_latency", vx_cyc - fall_cyc, 4);
        check("x60_duty", int'(Duty_X), 10);
        check("x60_err", int'(Err_X), 0);

        // Floor and boundaries on Y.
        by = vy_cnt;
        pulse(1'b1, 63, 30);
        check("y63_duty", int'(Duty_Y), 10);
        pulse(1'b1, 20, 30);
        check("y20_duty", int'(Duty_Y), 0);
        check("y20_err", int'(Err_Y), 0);
        pulse(1'b1, 271, 30);
        check("y271_duty", int'(Duty_Y), 62);
        check("y271_err", int'(Err_Y), 0);
        check("y_valid_cnt", vy_cnt - by, 3);

        // Range errors on X.
        pulse(1'b0, 15, 30);
        check("x15_duty", int'(Duty_X), 0);
        check("x15_err", int'(Err_X), 1);
        pulse(1'b0, 276, 30);
        check("x276_duty", int'(Duty_X), 63);
        check("x276_err", int'(Err_X), 1);
        pulse(1'b0, 60, 30);
        check("x60b_duty", int'(Duty_X), 10);
        check("x60b_err", int'(Err_X), 0);

        // Loss and recovery.
        check("lost_before", int'(Lost_X), 0);
        step(Timeout);
        check("lost_set", int'(Lost_X), 1);
        check("lost_duty_held", int'(Duty_X), 10);
        bx = vx_cnt;
        pulse(1'b0, 60, 30);
        check("lost_cleared", int'(Lost_X), 0);
        check("lost_valid_cnt", vx_cnt - bx, 1);

        // Reset in the middle of a pulse discards it.
        bx = vx_cnt;
        Pulse_X = 1'b1;
        step(30);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(30);
        Pulse_X = 1'b0;
        step(30);
        check("rst_mid_no_valid", vx_cnt - bx, 0);
        check("rst_mid_duty", int'(Duty_X), 0);
        pulse(1'b0, 60, 30);
        check("rst_mid_next_cnt", vx_cnt - bx, 1);
        check("rst_mid_next_duty", int'(Duty_X), 10);

        // Both channels strobe in the same cycle.
        bx = vx_cnt;
        by = vy_cnt;
        pulse_xy();
        check("xy_vx", vx_cnt - bx, 1);
        check("xy_vy", vy_cnt - by, 1);
        check("xy_same_cyc", vx_cyc - vy_cyc, 0);
        check("xy_duty_x", int'(Duty_X), 10);
        check("xy_duty_y", int'(Duty_Y), 15);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pwm_capture_xy.md
Name: pwm_capture_xy

Overview:
- Dual-channel servo-pulse decoder; the receive end of the pan/tilt PWM interface.
- Measures the high time of incoming Pulse_X / Pulse_Y waveforms and recovers the 6-bit duty codes that produced them.
- Used for loop-back self-check of the PWM generator and for slaving a second pan/tilt head to a master unit.
- Pulse model: high width W = BASE_TICKS + duty*STEP_TICKS sysclk cycles.

Parameters:
- BASE_TICKS, 100000, high width for duty 0, in sysclk cycles.
- STEP_TICKS, 1563, additional high cycles per duty LSB.
- TIMEOUT_TICKS, 3000000, cycles between rising edges before the channel is declared lost.

Ports:
- sysclk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- Pulse_X  in  1  asynchronous servo pulse input, X axis.
- Pulse_Y  in  1  asynchronous servo pulse input, Y axis.
- Duty_X  out  6  last decoded X duty.
- Duty_Y  out  6  last decoded Y duty.
- Valid_X  out  1  one-cycle strobe; Duty_X updated this cycle.
- Valid_Y  out  1  one-cycle strobe; Duty_Y updated this cycle.
- Err_X  out  1  last X pulse out of range.
- Err_Y  out  1  last Y pulse out of range.
- Lost_X  out  1  no X rising edge within TIMEOUT_TICKS.
- Lost_Y  out  1  no Y rising edge within TIMEOUT_TICKS.

Behaviour:
- One clock, sysclk. Reset is synchronous and active-high on port reset. All outputs are 0 while reset is asserted and on the first cycle after it.
- Input path, per channel:
  - 2-FF synchronizer, then a registered edge detect.
  - "Sampled edge" = edge as seen on the synchronizer output.
  - Channels are fully independent; identical logic is instantiated twice.
- Per-channel FSM:
  - ARM: entered from reset. If the sampled input is high, wait for a falling edge; a partial pulse is never decoded. Go to IDLE once the input is low.
  - IDLE: on a rising edge, clear the base and step counters and go to BASE.
  - BASE: count high cycles to BASE_TICKS, then go to STEP.
    - Falling edge in BASE: W < BASE_TICKS. Decode duty = 0, Err = 1, go to IDLE.
  - STEP: a sub-counter wraps every STEP_TICKS and increments a 7-bit step count, which saturates at 64.
    - Falling edge in STEP: duty = min(step count, 63). Err = 1 if step count = 64, else 0. Go to IDLE.
- Width accounting:
  - W counts cycles with the sampled input high, rising-edge cycle inclusive.
  - duty = floor((W - BASE_TICKS) / STEP_TICKS).
  - W exactly BASE_TICKS gives duty 0, no error.
  - W >= BASE_TICKS + 64*STEP_TICKS gives duty 63, Err = 1.
- Output timing:
  - Duty, Err and a one-cycle Valid are registered on the cycle after the sampled falling edge.
  - Fixed latency: 4 sysclk cycles from the raw pin falling edge.
  - Duty and Err hold until the next decode.
- Lost detection:
  - A per-channel period counter clears on every sampled rising edge and saturates at TIMEOUT_TICKS.
  - Lost asserts when the counter reaches TIMEOUT_TICKS; Duty is held.
  - Lost clears on the next Valid.
  - After reset, Lost asserts once TIMEOUT_TICKS elapses without an edge.
- A pulse still high at timeout stays in STEP and decodes normally when it falls; Lost is still set meanwhile.
- Reset mid-pulse: the FSM returns to ARM and the in-flight pulse is discarded.
- Valid_X and Valid_Y may assert in the same cycle.

Optional Feature:
- Macro: PWM_CAP_CONFIRM_EN.
- Defined: a decode is committed (Duty updated, Valid pulsed) only when it equals the immediately preceding decode of that channel.
  - A 6-bit shadow register plus a shadow-valid bit hold the previous decode.
  - The shadow-valid bit clears on reset, on Lost, and on any Err decode.
  - Err and Lost outputs behave as without the macro.
- Undefined: every decode is committed immediately.

Test Plan:
All scenarios use BASE_TICKS = 20, STEP_TICKS = 4, TIMEOUT_TICKS = 400.
- In-range decode: X high 60 cycles (20 + 4*10), then low 100 -> Duty_X = 10, Valid_X for 1 cycle, 4 cycles after the pin falls, Err_X = 0.
- Floor and boundaries: Y high 63 -> Duty_Y = 10. Y high 20 -> 0, Err = 0. Y high 271 (20 + 4*63 - 1) -> 62.
- Range errors: X high 15 -> Duty 0, Err_X = 1. X high 276 -> Duty 63, Err_X = 1. X high 60 next -> Err_X = 0.
- Loss: after one valid X pulse, hold X low 400 cycles -> Lost_X = 1, Duty_X held. Next 60-cycle pulse -> Lost_X = 0, Valid_X.
- Reset mid-pulse: X high for 30 cycles, reset 1 cycle, X high 30 more cycles -> no Valid_X for that pulse. Next 60-cycle pulse decodes 10.
- With PWM_CAP_CONFIRM_EN: X pulses 60, 64, 64 -> a single Valid_X with Duty_X = 11, on the third pulse. Simultaneous X = 60 and Y = 80 pulses -> Valid_X and Valid_Y in the same cycle.
